// File: rtl/wb_gpio_v2.sv
`default_nettype none
//==============================================================================
// Module      : wb_gpio_v2
// Description : Wishbone-classic GPIO with direction control, synchronised
//               input readback and per-pin edge interrupts (sticky, W1C).
// Revision    : 1.0 - initial release
//==============================================================================
module wb_gpio_v2 #(
   parameter int          WIDTH       = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] OUT_RESET   = 32'h0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      adr_i,
   input  logic [31:0]      dat_i,
   output logic [31:0]      dat_o,
   input  logic             we_i,
   input  logic [3:0]       sel_i,
   input  logic             stb_i,
   output logic             ack_o,
   input  logic             cyc_i,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq_o
);
   localparam int         c_BLANK          = SYNC_STAGES + 1;
   localparam logic [2:0] c_ADR_DATA_OUT   = 3'd0;
   localparam logic [2:0] c_ADR_DIR        = 3'd1;
   localparam logic [2:0] c_ADR_DATA_IN    = 3'd2;
   localparam logic [2:0] c_ADR_IRQ_EN     = 3'd3;
   localparam logic [2:0] c_ADR_IRQ_EDGE   = 3'd4;
   localparam logic [2:0] c_ADR_IRQ_STATUS = 3'd5;

   logic [WIDTH-1:0] r_data_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_irq_en;
   logic [WIDTH-1:0] r_irq_edge;
   logic [WIDTH-1:0] r_irq_status;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [2:0]       r_blank;
   logic             r_ack;
   logic [31:0]      r_dat;

   logic [2:0]       w_addr;
   logic             w_access;
   logic             w_wr;
   logic [31:0]      w_sel_mask;
   logic [WIDTH-1:0] w_wmask;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_data_in;
   logic [WIDTH-1:0] w_hit;
   logic [WIDTH-1:0] w_w1c;
   logic [31:0]      w_rd_word;
   logic             w_unused;

   function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_v,
                                                input logic [WIDTH-1:0] new_v,
                                                input logic [WIDTH-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   assign w_addr     = adr_i[4:2];
   assign w_access   = cyc_i & stb_i & ~r_ack;
   assign w_wr       = w_access & we_i;
   assign w_sel_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
   assign w_wmask    = w_sel_mask[WIDTH-1:0];
   assign w_wdata    = dat_i[WIDTH-1:0];
   assign w_data_in  = r_sync[SYNC_STAGES-1];
   assign w_unused   = ^{adr_i[31:5], adr_i[1:0], dat_i};

   // Edges are ignored until the synchroniser and prev flops hold real pad data.
   assign w_hit = (r_blank == 3'(c_BLANK)) ?
                  ((w_data_in & ~r_prev & r_irq_edge) | (~w_data_in & r_prev & ~r_irq_edge)) : '0;
   assign w_w1c = (w_wr && w_addr == c_ADR_IRQ_STATUS) ? (w_wdata & w_wmask) : '0;

   always_comb begin
      w_rd_word = '0;
      case (w_addr)
         c_ADR_DATA_OUT:   w_rd_word[WIDTH-1:0] = r_data_out;
         c_ADR_DIR:        w_rd_word[WIDTH-1:0] = r_dir;
         c_ADR_DATA_IN:    w_rd_word[WIDTH-1:0] = w_data_in;
         c_ADR_IRQ_EN:     w_rd_word[WIDTH-1:0] = r_irq_en;
         c_ADR_IRQ_EDGE:   w_rd_word[WIDTH-1:0] = r_irq_edge;
         c_ADR_IRQ_STATUS: w_rd_word[WIDTH-1:0] = r_irq_status;
         default:          w_rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack        <= 1'b0;
         r_dat        <= '0;
         r_data_out   <= OUT_RESET[WIDTH-1:0];
         r_dir        <= '0;
         r_irq_en     <= '0;
         r_irq_edge   <= '0;
         r_irq_status <= '0;
      end else begin
         r_ack <= w_access;
         if (w_access && !we_i)
            r_dat <= w_rd_word;
         if (w_wr) begin
            case (w_addr)
               c_ADR_DATA_OUT: r_data_out <= f_merge(r_data_out, w_wdata, w_wmask);
               c_ADR_DIR:      r_dir      <= f_merge(r_dir,      w_wdata, w_wmask);
               c_ADR_IRQ_EN:   r_irq_en   <= f_merge(r_irq_en,   w_wdata, w_wmask);
               c_ADR_IRQ_EDGE: r_irq_edge <= f_merge(r_irq_edge, w_wdata, w_wmask);
               default: ;
            endcase
         end
         // A new edge wins over a simultaneous clear of the same bit.
         r_irq_status <= (r_irq_status & ~w_w1c) | w_hit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            r_sync[i] <= '0;
         r_prev  <= '0;
         r_blank <= '0;
      end else begin
         r_sync[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
         r_prev <= w_data_in;
         if (r_blank != 3'(c_BLANK))
            r_blank <= r_blank + 3'd1;
      end
   end

   assign ack_o   = r_ack;
   assign dat_o   = r_dat;
   assign gpio_o  = r_data_out;
   assign gpio_oe = r_dir;
   assign irq_o   = |(r_irq_status & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_v2.sv
`default_nettype none
//==============================================================================
// Module      : tb_wb_gpio_v2
// Description : Directed self-checking bench for wb_gpio_v2 (WIDTH=8).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_wb_gpio_v2;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      adr_i = '0;
   logic [31:0]      dat_i = '0;
   logic [31:0]      dat_o;
   logic             we_i = 1'b0;
   logic [3:0]       sel_i = '0;
   logic             stb_i = 1'b0;
   logic             ack_o;
   logic             cyc_i = 1'b0;
   logic [WIDTH-1:0] gpio_i = '1;
   logic [WIDTH-1:0] gpio_o;
   logic [WIDTH-1:0] gpio_oe;
   logic             irq_o;

   int n_checks = 0;
   int n_errors = 0;

   wb_gpio_v2 #(.WIDTH(WIDTH), .SYNC_STAGES(2), .OUT_RESET(32'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
      .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .ack_o(ack_o), .cyc_i(cyc_i),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One classic cycle: ack must rise after one edge and last exactly one cycle.
   task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int k;
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
      k = 0;
      do begin
         @(posedge clk); #1; k++;
      end while (!ack_o && k < 8);
      chk("ack_rise", {31'b0, ack_o}, 32'd1);
      chk("ack_latency", k, 32'd1);
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      @(posedge clk); #1;
      chk("ack_pulse", {31'b0, ack_o}, 32'd0);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wb_cycle(1'b1, a, d, s);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      wb_cycle(1'b0, a, 32'h0, 4'hF);
      chk(tag, dat_o, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with pins held high
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gpio_o", {24'b0, gpio_o}, 32'hA5);
      chk("rst_gpio_oe", {24'b0, gpio_oe}, 32'h0);
      chk("rst_irq", {31'b0, irq_o}, 32'd0);
      chk("rst_ack", {31'b0, ack_o}, 32'd0);
      chk("rst_dat_o", dat_o, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(posedge clk);
      rd_chk("rd_data_out", 32'h00, 32'hA5);
      rd_chk("rd_dir", 32'h04, 32'h0);
      rd_chk("rd_data_in", 32'h08, 32'hFF);
      rd_chk("rd_irq_en", 32'h0C, 32'h0);
      rd_chk("rd_irq_edge", 32'h10, 32'h0);
      rd_chk("rd_irq_status", 32'h14, 32'h0);

      // Byte-select writes; upper bits dropped
      wb_write(32'h04, 32'hFFFF_FF0F, 4'b0001);
      chk("dir_oe", {24'b0, gpio_oe}, 32'h0F);
      wb_write(32'h00, 32'hABCD_EF3C, 4'b1111);
      chk("dout_gpio_o", {24'b0, gpio_o}, 32'h3C);
      wb_write(32'h00, 32'hFFFF_FFFF, 4'b0000);
      chk("sel0_gpio_o", {24'b0, gpio_o}, 32'h3C);
      rd_chk("rd_dout_upper0", 32'h00, 32'h3C);

      // Rising edge on bit3, enabled
      wb_write(32'h10, 32'h08, 4'b0001);
      wb_write(32'h0C, 32'h08, 4'b0001);
      gpio_i = 8'hF7;
      repeat (4) @(posedge clk);
      #1;
      rd_chk("fall3_no_hit", 32'h14, 32'h0);
      gpio_i = 8'hFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rise3_irq_early", {31'b0, irq_o}, 32'd0);
      @(posedge clk); #1;
      chk("rise3_irq", {31'b0, irq_o}, 32'd1);
      rd_chk("rise3_data_in", 32'h08, 32'hFF);
      rd_chk("rise3_status", 32'h14, 32'h08);
      wb_write(32'h14, 32'h08, 4'b0001);
      chk("w1c3_irq", {31'b0, irq_o}, 32'd0);
      rd_chk("w1c3_status", 32'h14, 32'h0);

      // Falling edge on bit0, not enabled
      gpio_i = 8'hFE;
      repeat (4) @(posedge clk);
      #1;
      chk("fall0_irq_masked", {31'b0, irq_o}, 32'd0);
      rd_chk("fall0_status", 32'h14, 32'h01);
      wb_write(32'h0C, 32'h09, 4'b0001);
      chk("en0_irq", {31'b0, irq_o}, 32'd1);

      // W1C of bit5 on the same edge its rising hit lands
      wb_write(32'h10, 32'h28, 4'b0001);
      gpio_i = 8'hDE;
      repeat (4) @(posedge clk);
      #1;
      rd_chk("fall5_no_hit", 32'h14, 32'h01);
      gpio_i = 8'hFE;
      @(posedge clk);
      @(posedge clk);
      wb_write(32'h14, 32'h20, 4'b0001);
      rd_chk("set_wins_status", 32'h14, 32'h21);
      wb_write(32'h14, 32'h20, 4'b0001);
      rd_chk("w1c5_status", 32'h14, 32'h01);

      // Unmapped addresses
      rd_chk("rd_unmapped_1c", 32'h1C, 32'h0);
      wb_write(32'h1C, 32'hFFFF_FFFF, 4'b1111);
      rd_chk("rd_unmapped_18", 32'h18, 32'h0);
      rd_chk("post_unm_dout", 32'h00, 32'h3C);
      rd_chk("post_unm_dir", 32'h04, 32'h0F);
      rd_chk("post_unm_en", 32'h0C, 32'h09);
      rd_chk("post_unm_edge", 32'h10, 32'h28);
      wb_write(32'h1C, 32'h0, 4'b1111);
      chk("dat_o_hold", dat_o, 32'h28);

      // Reset during an acknowledged write
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h04; dat_i = 32'hFF; sel_i = 4'hF;
      @(posedge clk); #1;
      chk("midrst_ack_hi", {31'b0, ack_o}, 32'd1);
      chk("midrst_oe_hi", {24'b0, gpio_oe}, 32'hFF);
      rst_n = 1'b0;
      #1;
      chk("midrst_ack", {31'b0, ack_o}, 32'd0);
      chk("midrst_oe", {24'b0, gpio_oe}, 32'h0);
      chk("midrst_gpio_o", {24'b0, gpio_o}, 32'hA5);
      chk("midrst_irq", {31'b0, irq_o}, 32'd0);
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk);
      rd_chk("post_rst_dir", 32'h04, 32'h0);
      rd_chk("post_rst_status", 32'h14, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
